// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling feeding a first-word-fall-through byte FIFO.
// Build option: define UART_RX_PARITY_EN to require an even-parity bit between data and stop.
module uart_rx_fifo #(
  parameter int unsigned CLK_DIV = 27,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic               wb_clk,
  input  logic               rst_n,
  input  logic               rx_i,
  output logic [7:0]         data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [FIFO_AW:0]   fifo_count_o,
  output logic               frame_err_o,
  output logic               overrun_o,
  output logic               parity_err_o
);

  localparam int unsigned TCW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PW    = FIFO_AW + 1;
  localparam int unsigned DEPTH = 1 << FIFO_AW;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
  } state_e;
`endif

  state_e           state_q, state_d;
  logic             meta_q, rxs_q;
  logic [TCW-1:0]   tcnt_q, tcnt_d;
  logic             tick_c;
  logic [3:0]       scnt_q, scnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             push_c, ferr_c;
  logic             frame_err_q, overrun_q;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
  logic             perr_c, parity_err_q;
`endif

  logic [7:0]       mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]    count_c;
  logic             full_c, pop_c, wr_en_c, ovr_c;

  // Two-flop synchronizer; idle-high line resets to 1 so reset never looks like a start bit
  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      meta_q <= rx_i;
      rxs_q  <= meta_q;
    end
  end

  // Oversample tick; held at zero while idle so the first tick follows start detect by CLK_DIV cycles
  assign tick_c = (tcnt_q == TCW'(CLK_DIV - 1));

  always_comb begin
    tcnt_d = tcnt_q + TCW'(1);
    if (state_q == IDLE || tick_c) begin
      tcnt_d = '0;
    end
  end

  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      scnt_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      scnt_q  <= scnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Frame FSM: start verified at scnt 7, every later bit sampled at scnt 15 (mid-bit)
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    push_c  = 1'b0;
    ferr_c  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_c  = 1'b0;
`endif
    if (tick_c) begin
      scnt_d = scnt_q + 4'd1;
    end
    case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          scnt_d  = '0;
        end
      end
      START: begin
        if (tick_c && scnt_q == 4'd7) begin
          if (rxs_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            scnt_d  = '0;
            idx_d   = '0;
          end
        end
      end
      DATA: begin
        if (tick_c && scnt_q == 4'd15) begin
          shift_d[idx_q] = rxs_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_c && scnt_q == 4'd15) begin
          par_d   = rxs_q;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick_c && scnt_q == 4'd15) begin
`ifdef UART_RX_PARITY_EN
          perr_c = ^{shift_q, par_q};
          if (rxs_q) begin
            push_c  = !perr_c;
            state_d = IDLE;
          end else begin
            ferr_c  = 1'b1;
            state_d = WAIT_HIGH;
          end
`else
          if (rxs_q) begin
            push_c  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_c  = 1'b1;
            state_d = WAIT_HIGH;
          end
`endif
        end
      end
      WAIT_HIGH: begin
        if (rxs_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO control: a pop in the same cycle frees room for a push into a full FIFO
  assign count_c = wr_ptr_q - rd_ptr_q;
  assign full_c  = (count_c == PW'(DEPTH));
  assign valid_o = (count_c != '0);
  assign pop_c   = valid_o && ready_i;
  assign wr_en_c = push_c && (!full_c || pop_c);
  assign ovr_c   = push_c && full_c && !pop_c;

  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_c) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wr_en_c) begin
      mem[wr_ptr_q[FIFO_AW-1:0]] <= shift_q;
    end
  end

  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= ferr_c;
      overrun_q   <= ovr_c;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= perr_c;
    end
  end
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

  // Head byte is masked while empty so reset presents zero instead of stale RAM
  assign data_o       = valid_o ? mem[rd_ptr_q[FIFO_AW-1:0]] : 8'h00;
  assign fifo_count_o = count_c;
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: drives serial frames and checks received bytes, FIFO level and error pulses.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned FIFO_AW = 4;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned BIT     = 16 * CLK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  // Edge (counted from the start-bit drive) that registers the push: 2 sync flops + 1 detect
  // cycle, then CLK_DIV cycles per tick up to the stop-bit mid-sample tick.
  localparam int unsigned PUSH_EDGE = 3 + CLK_DIV * (8 + 16 * (FRAME_BITS - 1));

  logic             wb_clk = 1'b0;
  logic             rst_n  = 1'b0;
  logic             rx_i   = 1'b1;
  logic             ready_i = 1'b0;
  logic [7:0]       data_o;
  logic             valid_o;
  logic [FIFO_AW:0] fifo_count_o;
  logic             frame_err_o, overrun_o, parity_err_o;

  int n_cmp = 0;
  int n_bad = 0;
  int ferr_n = 0;
  int ovr_n = 0;
  int perr_n = 0;
  logic [7:0] got_q[$];
`ifdef UART_RX_PARITY_EN
  logic bad_par = 1'b0;
`endif

  uart_rx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
    .wb_clk       (wb_clk),
    .rst_n        (rst_n),
    .rx_i         (rx_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .fifo_count_o (fifo_count_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .parity_err_o (parity_err_o)
  );

  always #5 wb_clk = ~wb_clk;

  // Record consumer handshakes and pulse cycles away from the active edge
  always @(negedge wb_clk) begin
    if (rst_n) begin
      if (valid_o && ready_i) got_q.push_back(data_o);
      if (frame_err_o) ferr_n++;
      if (overrun_o) ovr_n++;
      if (parity_err_o) perr_n++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge wb_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    rx_i = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      wait_clk(BIT);
    end
`ifdef UART_RX_PARITY_EN
    rx_i = (^b) ^ bad_par;
    wait_clk(BIT);
`endif
    rx_i = stop_b;
    wait_clk(BIT);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx_i = 1'b1; ready_i = 1'b0;
    repeat (4) @(posedge wb_clk);
    @(negedge wb_clk);
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    n_cmp++; if (fifo_count_o !== 5'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count_o); end
    n_cmp++; if (data_o !== 8'h00) begin n_bad++; $display("FAIL reset_data got=%h exp=00", data_o); end
    n_cmp++; if ({frame_err_o, overrun_o, parity_err_o} !== 3'b000) begin
      n_bad++; $display("FAIL reset_errs got=%b exp=000", {frame_err_o, overrun_o, parity_err_o}); end
    @(posedge wb_clk); #1;
    rst_n = 1'b1;
    wait_clk(BIT);
  endtask

  task automatic test_single_timing;
    int base;
    base = got_q.size();
    ready_i = 1'b1;
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (PUSH_EDGE - 1) @(posedge wb_clk);
        @(negedge wb_clk);
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL early_valid got=%b exp=0", valid_o); end
        @(posedge wb_clk); @(negedge wb_clk);
        n_cmp++; if (valid_o !== 1'b1 || data_o !== 8'h55) begin
          n_bad++; $display("FAIL push_latency got valid=%b data=%h exp valid=1 data=55", valid_o, data_o); end
        @(posedge wb_clk); @(negedge wb_clk);
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL pop_drop got=%b exp=0", valid_o); end
      end
    join
    wait_clk(BIT);
    n_cmp++; if (got_q.size() != base + 1) begin
      n_bad++; $display("FAIL single_count got=%0d exp=1", got_q.size() - base); end
  endtask

  task automatic test_glitch;
    int base, f0;
    base = got_q.size(); f0 = ferr_n;
    ready_i = 1'b1;
    rx_i = 1'b0;
    wait_clk(20);
    rx_i = 1'b1;
    wait_clk(2 * BIT);
    n_cmp++; if (fifo_count_o !== 5'd0 || valid_o !== 1'b0) begin
      n_bad++; $display("FAIL glitch_count got=%0d/%b exp=0/0", fifo_count_o, valid_o); end
    n_cmp++; if (ferr_n != f0 || got_q.size() != base) begin
      n_bad++; $display("FAIL glitch_effect got ferr=%0d bytes=%0d exp 0/0", ferr_n - f0, got_q.size() - base); end
    send_frame(8'h3C, 1'b1);
    wait_clk(BIT);
    n_cmp++; if (got_q.size() != base + 1 || got_q[base] !== 8'h3C) begin
      n_bad++; $display("FAIL glitch_next got=%0d bytes exp 1 byte 3c", got_q.size() - base); end
  endtask

  task automatic test_break;
    int base, f0;
    base = got_q.size(); f0 = ferr_n;
    ready_i = 1'b1;
    send_frame(8'hA5, 1'b0);
    wait_clk(200);
    n_cmp++; if (fifo_count_o !== 5'd0) begin n_bad++; $display("FAIL break_count got=%0d exp=0", fifo_count_o); end
    rx_i = 1'b1;
    wait_clk(BIT);
    n_cmp++; if (ferr_n != f0 + 1) begin n_bad++; $display("FAIL break_ferr got=%0d exp=1", ferr_n - f0); end
    n_cmp++; if (got_q.size() != base) begin n_bad++; $display("FAIL break_push got=%0d exp=0", got_q.size() - base); end
    send_frame(8'h3C, 1'b1);
    wait_clk(BIT);
    n_cmp++; if (got_q.size() != base + 1 || got_q[base] !== 8'h3C || ferr_n != f0 + 1) begin
      n_bad++; $display("FAIL break_next got bytes=%0d ferr=%0d exp 1/1", got_q.size() - base, ferr_n - f0); end
  endtask

  task automatic test_overrun;
    int base, o0;
    logic [7:0] exp_q[$];
    base = got_q.size(); o0 = ovr_n;
    ready_i = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      send_frame(8'(i), 1'b1);
      if (i < DEPTH) exp_q.push_back(8'(i));
    end
    wait_clk(4);
    n_cmp++; if (fifo_count_o !== 5'(DEPTH)) begin n_bad++; $display("FAIL full_count got=%0d exp=%0d", fifo_count_o, DEPTH); end
    n_cmp++; if (ovr_n != o0 + 1) begin n_bad++; $display("FAIL overrun_pulses got=%0d exp=1", ovr_n - o0); end
    n_cmp++; if (data_o !== 8'h00) begin n_bad++; $display("FAIL full_head got=%h exp=00", data_o); end
    // push and pop coincide on a full FIFO: both happen, no overrun
    fork
      send_frame(8'h11, 1'b1);
      begin
        repeat (PUSH_EDGE - 1) @(posedge wb_clk);
        #1; ready_i = 1'b1;
        @(posedge wb_clk);
        #1; ready_i = 1'b0;
      end
    join
    exp_q.push_back(8'h11);
    n_cmp++; if (fifo_count_o !== 5'(DEPTH) || ovr_n != o0 + 1) begin
      n_bad++; $display("FAIL full_pushpop got count=%0d ovr=%0d exp %0d/1", fifo_count_o, ovr_n - o0, DEPTH); end
    ready_i = 1'b1;
    wait_clk(3 * DEPTH);
    n_cmp++; if (got_q.size() != base + exp_q.size()) begin
      n_bad++; $display("FAIL drain_len got=%0d exp=%0d", got_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      n_cmp++; if (got_q[base + i] !== exp_q[i]) begin
        n_bad++; $display("FAIL drain_byte[%0d] got=%h exp=%h", i, got_q[base + i], exp_q[i]); end
    end
  endtask

  task automatic test_count1_pushpop;
    int base;
    logic [7:0] a, b;
    a = 8'($urandom); b = 8'($urandom);
    base = got_q.size();
    ready_i = 1'b0;
    send_frame(a, 1'b1);
    n_cmp++; if (fifo_count_o !== 5'd1 || data_o !== a) begin
      n_bad++; $display("FAIL one_hold got count=%0d data=%h exp 1/%h", fifo_count_o, data_o, a); end
    fork
      send_frame(b, 1'b1);
      begin
        repeat (PUSH_EDGE - 1) @(posedge wb_clk);
        #1; ready_i = 1'b1;
        @(posedge wb_clk);
        #1; ready_i = 1'b0;
      end
    join
    n_cmp++; if (fifo_count_o !== 5'd1 || data_o !== b) begin
      n_bad++; $display("FAIL one_pushpop got count=%0d data=%h exp 1/%h", fifo_count_o, data_o, b); end
    ready_i = 1'b1;
    wait_clk(4);
    n_cmp++; if (got_q.size() != base + 2 || got_q[base] !== a || got_q[base + 1] !== b) begin
      n_bad++; $display("FAIL one_order got=%0d bytes exp %h,%h", got_q.size() - base, a, b); end
  endtask

  task automatic test_back_to_back;
    int base;
    logic done;
    logic [7:0] exp_q[$];
    base = got_q.size();
    done = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(8'($urandom));
    fork
      begin
        for (int i = 0; i < 8; i++) send_frame(exp_q[i], 1'b1);
        done = 1'b1;
      end
      while (!done) begin
        @(posedge wb_clk); #1;
        ready_i = 1'($urandom_range(0, 1));
      end
    join
    ready_i = 1'b1;
    wait_clk(BIT);
    n_cmp++; if (got_q.size() != base + 8) begin
      n_bad++; $display("FAIL b2b_len got=%0d exp=8", got_q.size() - base); end
    for (int i = 0; i < 8 && base + i < got_q.size(); i++) begin
      n_cmp++; if (got_q[base + i] !== exp_q[i]) begin
        n_bad++; $display("FAIL b2b_byte[%0d] got=%h exp=%h", i, got_q[base + i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid;
    int base, f0;
    logic [7:0] x, p;
    x = 8'($urandom); p = 8'($urandom);
    ready_i = 1'b0;
    send_frame(x, 1'b1);
    n_cmp++; if (fifo_count_o !== 5'd1) begin n_bad++; $display("FAIL pre_reset_count got=%0d exp=1", fifo_count_o); end
    rx_i = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 3; i++) begin rx_i = p[i]; wait_clk(BIT); end
    rx_i = p[3];
    wait_clk(BIT / 2);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (fifo_count_o !== 5'd0 || valid_o !== 1'b0) begin
      n_bad++; $display("FAIL async_reset got count=%0d valid=%b exp 0/0", fifo_count_o, valid_o); end
    repeat (3) @(posedge wb_clk);
    @(negedge wb_clk);
    n_cmp++; if ({valid_o, fifo_count_o, data_o, frame_err_o, overrun_o, parity_err_o} !== 17'd0) begin
      n_bad++; $display("FAIL midreset_outs got valid=%b cnt=%0d data=%h errs=%b%b%b exp all 0",
                        valid_o, fifo_count_o, data_o, frame_err_o, overrun_o, parity_err_o); end
    @(posedge wb_clk); #1;
    rx_i = 1'b1;
    rst_n = 1'b1;
    wait_clk(2 * BIT);
    base = got_q.size(); f0 = ferr_n;
    ready_i = 1'b1;
    send_frame(8'hC3, 1'b1);
    wait_clk(BIT);
    n_cmp++; if (got_q.size() != base + 1 || got_q[base] !== 8'hC3 || ferr_n != f0) begin
      n_bad++; $display("FAIL post_reset_rx got bytes=%0d ferr=%0d exp 1 byte c3, 0 ferr", got_q.size() - base, ferr_n - f0); end
  endtask

  task automatic test_parity;
`ifdef UART_RX_PARITY_EN
    int base, p0;
    base = got_q.size(); p0 = perr_n;
    ready_i = 1'b1;
    bad_par = 1'b0;
    send_frame(8'h01, 1'b1);
    wait_clk(BIT);
    n_cmp++; if (got_q.size() != base + 1 || got_q[base] !== 8'h01 || perr_n != p0) begin
      n_bad++; $display("FAIL parity_good got bytes=%0d perr=%0d exp 1/0", got_q.size() - base, perr_n - p0); end
    bad_par = 1'b1;
    send_frame(8'h01, 1'b1);
    bad_par = 1'b0;
    wait_clk(BIT);
    n_cmp++; if (perr_n != p0 + 1 || got_q.size() != base + 1 || fifo_count_o !== 5'd0) begin
      n_bad++; $display("FAIL parity_bad got perr=%0d bytes=%0d exp 1/1", perr_n - p0, got_q.size() - base); end
`else
    n_cmp++; if (perr_n != 0) begin n_bad++; $display("FAIL parity_tied got=%0d exp=0", perr_n); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_timing();
    test_glitch();
    test_break();
    test_overrun();
    test_count1_pushpop();
    test_back_to_back();
    test_reset_mid();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver for the serial stream driven by the SoC `uart0_stx_pad_o`.
- Format: 8N1 by default, LSB first, 16x oversampling.
- Received bytes go into a first-word-fall-through FIFO with a valid/ready output.
- Used in benches to capture console output from the core, and synthesizable for use as a board-side loopback receiver.

Parameters:
- CLK_DIV, 27, system clocks per 16x oversample tick (50 MHz / (115200*16) ≈ 27); legal values ≥ 2.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW.

Ports:
- wb_clk  in  1  system clock, all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_i  in  1  serial input, idle high, asynchronous to wb_clk.
- data_o  out  8  head-of-FIFO byte; valid only while valid_o=1.
- valid_o  out  1  FIFO not empty.
- ready_i  in  1  consumer accepts data_o when valid_o&&ready_i.
- fifo_count_o  out  FIFO_AW+1  bytes currently stored.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- overrun_o  out  1  one-cycle pulse: byte dropped because FIFO full.
- parity_err_o  out  1  one-cycle pulse: parity mismatch (see Optional Feature).

Behaviour:
- Reset values: valid_o=0, fifo_count_o=0, frame_err_o=0, overrun_o=0, parity_err_o=0, data_o=0.
- Reset also clears FSM to IDLE, both synchronizer flops to 1, the tick counter to 0, and the FIFO pointers.
- Reset mid-frame discards the partial byte.
- Synchronizer: 2 flops on rx_i; the FSM uses only the synchronized value rxs.
- Tick generator: counter 0..CLK_DIV-1.
  - tick=1 for one cycle when the counter wraps.
  - Free-running except in IDLE, where it is held at 0 so that the first tick lands CLK_DIV cycles after start detect.
- Sample counter: 4-bit scnt, increments on tick, wraps 15->0.
- FSM states: IDLE, START, DATA, PARITY (feature only), STOP, WAIT_HIGH.
  - IDLE: rxs==0 -> START, scnt=0.
  - START: on tick with scnt==7, if rxs==1 -> IDLE (glitch rejected, no error); else scnt=0, bit index=0 -> DATA.
  - DATA: on tick with scnt==15 (mid-bit), shift rxs into bit[index], LSB first; after index 7 -> STOP (or PARITY).
  - STOP: on tick with scnt==15:
    - rxs==1 -> push byte, -> IDLE.
    - rxs==0 -> frame_err_o pulse, byte discarded, -> WAIT_HIGH.
  - WAIT_HIGH: stays until rxs==1, then -> IDLE. A break (continuous low) yields exactly one frame_err_o.
- Push timing: push occurs in the cycle of the stop-bit mid-sample tick. fifo_count_o and valid_o update on the next edge (latency 1 cycle).
- FIFO:
  - Dual-pointer RAM, pointers FIFO_AW+1 bits wide (wrap bit distinguishes full from empty).
  - data_o = mem[rd_ptr], combinational from registered pointer (FWFT).
  - Pop when valid_o&&ready_i; ready_i while empty is ignored.
  - Push while full and no pop -> byte dropped, overrun_o pulse, contents unchanged.
  - Push and pop in the same cycle while full -> both performed, count stays at depth, no overrun.
  - Push and pop in the same cycle while count==1 -> count stays 1, data_o advances to the new byte.
- Error pulses are independent and never asserted in the same cycle as a successful push.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - After DATA the FSM enters PARITY and samples one extra bit at mid-bit.
  - Even parity required: XOR of 8 data bits and the parity bit == 0.
  - Mismatch -> parity_err_o pulse at the stop-bit sample, byte not pushed. The STOP check still runs, so frame_err_o can also pulse.
- Undefined: no PARITY state, parity_err_o tied to 0, frame is 10 bits.

Test Plan:
- CLK_DIV=4 (1 bit = 64 clocks), ready_i=1, send 0x55 -> valid_o rises 1 cycle after the stop-bit mid-sample, data_o=0x55, then valid_o drops next cycle.
- rx_i low for 20 clocks then high -> no push, no frame_err_o, FSM back in IDLE; a following 0x3C is received correctly.
- Send 0xA5 with stop bit driven 0 and held low 200 clocks, then 0x3C -> exactly one frame_err_o pulse, fifo_count_o stays 0, then 0x3C is received.
- ready_i=0, FIFO_AW=4, send bytes 0x00..0x10 (17 bytes) -> fifo_count_o=16, one overrun_o pulse on the 17th. Then ready_i=1 drains 0x00..0x0F in order.
- rst_n low for 3 clocks during data bit 3 -> all outputs at reset values; next full frame 0xC3 is received correctly.
- With UART_RX_PARITY_EN: send 0x01 with parity 1 -> received; send 0x01 with parity 0 -> parity_err_o pulse, count unchanged.
